// File: rtl/f1_reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : f1_reaction_timer
// Brief    : F1 start-light controller/monitor. Gates the light sequencer,
//            holds a pseudo-random all-on time and times the driver reaction.
// Revision : 1.0 - initial release
// ============================================================================
module f1_reaction_timer #(
    parameter int MIN_HOLD = 200,
    parameter int TIME_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              trigger,
    input  logic [7:0]        lights_in,
    output logic              seq_en,
    output logic              seq_rst,
    output logic              lights_off,
    output logic [TIME_W-1:0] react_time,
    output logic              time_valid,
    output logic              jump_start,
    output logic              seq_err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ARMED = 3'd1;
    localparam logic [2:0] c_HOLD  = 3'd2;
    localparam logic [2:0] c_GO    = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [TIME_W-1:0] c_CNT_MAX = '1;

    logic [2:0]        r_state;
    logic [6:0]        r_lfsr;
    logic [7:0]        r_prev;
    logic [TIME_W-1:0] r_hold_cnt;
    logic [TIME_W-1:0] r_react_cnt;
    logic [TIME_W-1:0] r_react_time;
    logic              r_time_valid;
    logic              r_jump_start;
    logic              r_seq_rst;
    logic              r_lights_off;
    logic              r_seq_err;

    logic [2:0]        w_state_nxt;
    logic [7:0]        w_prev_nxt;
    logic [TIME_W-1:0] w_hold_nxt;
    logic [TIME_W-1:0] w_react_nxt;
    logic [TIME_W-1:0] w_react_time_nxt;
    logic [TIME_W-1:0] w_hold_load;
    logic              w_valid;
    logic              w_jump;
    logic              w_bad;
    logic              w_seq_en;

    // Wraps modulo 2^TIME_W when MIN_HOLD + LFSR does not fit the counter.
    assign w_hold_load = TIME_W'(MIN_HOLD) + TIME_W'(r_lfsr);

    always_comb begin
        w_state_nxt      = r_state;
        w_prev_nxt       = r_prev;
        w_hold_nxt       = r_hold_cnt;
        w_react_nxt      = r_react_cnt;
        w_react_time_nxt = r_react_time;
        w_valid          = 1'b0;
        w_jump           = 1'b0;
        w_bad            = 1'b0;
        w_seq_en         = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ARMED;
                    w_prev_nxt  = 8'h00;
                end
            end
            c_ARMED: begin
                w_seq_en   = en;
                w_prev_nxt = lights_in;
                if (lights_in != r_prev && lights_in != {r_prev[6:0], 1'b1}) begin
                    w_bad = 1'b1;
                end else if (trigger) begin
                    w_jump = 1'b1;
                end else if (lights_in == 8'hFF) begin
                    w_state_nxt = c_HOLD;
                    w_hold_nxt  = w_hold_load;
                end
            end
            c_HOLD: begin
                w_seq_en = en && (r_hold_cnt == '0);
                if (lights_in != 8'hFF) begin
                    w_bad = 1'b1;
                end else if (trigger) begin
                    w_jump = 1'b1;
                end else if (en) begin
                    if (r_hold_cnt == '0) begin
                        w_state_nxt = c_GO;
                        w_react_nxt = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt - 1'b1;
                    end
                end
            end
            c_GO: begin
                if (lights_in != 8'h00) begin
                    w_bad = 1'b1;
                end else if (trigger) begin
                    // Captures the count before this cycle's tick, if any.
                    w_react_time_nxt = r_react_cnt;
                    w_valid          = 1'b1;
                    w_state_nxt      = c_DONE;
                end else if (en && r_react_cnt != c_CNT_MAX) begin
                    w_react_nxt = r_react_cnt + 1'b1;
                end
            end
            c_DONE: begin
                if (!trigger) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
        if (w_bad) begin
            w_state_nxt = c_IDLE;
        end else if (w_jump) begin
            w_state_nxt = c_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_lfsr       <= 7'h01;
            r_prev       <= 8'h00;
            r_hold_cnt   <= '0;
            r_react_cnt  <= '0;
            r_react_time <= '0;
            r_time_valid <= 1'b0;
            r_jump_start <= 1'b0;
            r_seq_rst    <= 1'b0;
            r_lights_off <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lfsr       <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
            r_prev       <= w_prev_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_react_cnt  <= w_react_nxt;
            r_react_time <= w_react_time_nxt;
            r_time_valid <= w_valid;
            r_jump_start <= w_jump;
            r_seq_rst    <= w_bad | w_jump;
            r_lights_off <= (w_state_nxt == c_GO);
            r_seq_err    <= r_seq_err | w_bad;
        end
    end

    assign seq_en     = w_seq_en;
    assign seq_rst    = r_seq_rst;
    assign lights_off = r_lights_off;
    assign react_time = r_react_time;
    assign time_valid = r_time_valid;
    assign jump_start = r_jump_start;
    assign seq_err    = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_f1_reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_f1_reaction_timer
// Brief    : Self-checking bench for f1_reaction_timer with sequencer models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_f1_reaction_timer;

    localparam int MIN_HOLD = 200;
    localparam int TW       = 16;
    localparam int TW2      = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, start, trigger;
    logic [7:0]    seq_lights, force_val, lights_in;
    logic          force_on;
    logic          seq_en, seq_rst, lights_off, time_valid, jump_start, seq_err;
    logic [TW-1:0] react_time;

    logic           start2, trig2;
    logic [7:0]     lights2;
    logic           seq_en2, seq_rst2, lights_off2, time_valid2, jump_start2, seq_err2;
    logic [TW2-1:0] react_time2;

    assign lights_in = force_on ? force_val : seq_lights;

    f1_reaction_timer #(.MIN_HOLD(MIN_HOLD), .TIME_W(TW)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .trigger(trigger),
        .lights_in(lights_in), .seq_en(seq_en), .seq_rst(seq_rst),
        .lights_off(lights_off), .react_time(react_time), .time_valid(time_valid),
        .jump_start(jump_start), .seq_err(seq_err)
    );

    f1_reaction_timer #(.MIN_HOLD(2), .TIME_W(TW2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .start(start2), .trigger(trig2),
        .lights_in(lights2), .seq_en(seq_en2), .seq_rst(seq_rst2),
        .lights_off(lights_off2), .react_time(react_time2), .time_valid(time_valid2),
        .jump_start(jump_start2), .seq_err(seq_err2)
    );

    // Light sequencer models: shift in a 1 per advance, wrap FF->00.
    always_ff @(posedge clk) begin
        if (rst || seq_rst) seq_lights <= 8'h00;
        else if (seq_en) seq_lights <= (seq_lights == 8'hFF) ? 8'h00 : {seq_lights[6:0], 1'b1};
    end
    always_ff @(posedge clk) begin
        if (rst || seq_rst2) lights2 <= 8'h00;
        else if (seq_en2) lights2 <= (lights2 == 8'hFF) ? 8'h00 : {lights2[6:0], 1'b1};
    end

    logic [6:0] m_lfsr;
    always_ff @(posedge clk) begin
        if (rst) m_lfsr <= 7'h01;
        else m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    int            gap     = 4;
    int            en_cnt  = 0;
    logic          last_en = 1'b0;
    logic [TW-1:0] exp_react_m = '0;
    logic          exp_err_m   = 1'b0;

    typedef struct {
        int            kind;
        int            arg;
        int            gp;
        logic          trig;
        logic [TW-1:0] exp_react;
        logic          exp_err;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        en     = (en_cnt == 0);
        en_cnt = en ? gap - 1 : en_cnt - 1;
        @(posedge clk);
        #1;
        last_en = en;
    endtask

    task automatic wait_lights(input logic [7:0] lvl);
        int t = 0;
        while (lights_in !== lvl && t < 4000) begin step(); t++; end
        check("wait_lights", lights_in, lvl);
    endtask

    task automatic wait_en();
        int t = 0;
        while (en !== 1'b1 && t < 10) begin step(); t++; end
    endtask

    task automatic run_normal(input int ticks, input int gp, input int held);
        int t, nt, steps, exp_hold;
        logic [7:0] pl;
        gap = gp;
        start = 1'b1; step(); start = 1'b0;
        steps = 0; pl = lights_in; t = 0;
        while (lights_in !== 8'hFF && t < 4000) begin
            step(); t++;
            if (lights_in !== pl) begin
                if (lights_in !== {pl[6:0], 1'b1}) check("light_step", lights_in, {pl[6:0], 1'b1});
                steps++;
                pl = lights_in;
            end
        end
        check("steps_to_ff", steps, 8);
        exp_hold = ((MIN_HOLD + int'(m_lfsr)) % (1 << TW)) + 1;
        step();
        nt = 0; t = 0;
        while (lights_off !== 1'b1 && t < 20000) begin step(); t++; if (last_en) nt++; end
        check("hold_ticks", nt, exp_hold);
        check("lights_at_go", lights_in, 8'h00);
        nt = 0; t = 0;
        while (nt < ticks && t < 20000) begin step(); t++; if (last_en) nt++; end
        trigger = 1'b1; step();
        exp_react_m = (ticks > (1 << TW) - 1) ? TW'((1 << TW) - 1) : TW'(ticks);
        check("time_valid", time_valid, 1);
        check("react_time", react_time, exp_react_m);
        check("lights_off_done", lights_off, 0);
        for (int i = 0; i < held; i++) begin
            start = (i == 1);
            step();
            check("done_valid_low", time_valid, 0);
            check("done_no_arm", seq_en, 0);
        end
        start = 1'b0;
        trigger = 1'b0; step();
        check("valid_pulse", time_valid, 0);
        check("seq_err_run", seq_err, exp_err_m);
    endtask

    task automatic run_jump(input logic [7:0] lvl, input int gp);
        gap = gp;
        start = 1'b1; step(); start = 1'b0;
        wait_lights(lvl);
        trigger = 1'b1; step();
        check("jump_start", jump_start, 1);
        check("jump_seq_rst", seq_rst, 1);
        check("jump_no_valid", time_valid, 0);
        check("jump_react", react_time, exp_react_m);
        check("jump_err", seq_err, exp_err_m);
        trigger = 1'b0; step();
        check("jump_pulse", jump_start, 0);
        check("jump_rst_pulse", seq_rst, 0);
    endtask

    task automatic run_bad(input logic [7:0] lvl, input logic [7:0] val, input logic trg, input int gp);
        gap = gp;
        start = 1'b1; step(); start = 1'b0;
        wait_lights(lvl);
        force_val = val; force_on = 1'b1; trigger = trg;
        step();
        force_on = 1'b0; trigger = 1'b0;
        exp_err_m = 1'b1;
        check("bad_err", seq_err, 1);
        check("bad_seq_rst", seq_rst, 1);
        check("bad_no_jump", jump_start, 0);
        step();
        check("bad_rst_pulse", seq_rst, 0);
        wait_en();
        check("bad_idle_seq_en", seq_en, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; trigger = 1'b0;
        force_on = 1'b0; force_val = 8'h00; start2 = 1'b0; trig2 = 1'b0;
        step(); step(); step();
        check("rst_seq_rst", seq_rst, 0);
        check("rst_lights_off", lights_off, 0);
        check("rst_react", react_time, 0);
        check("rst_valid", time_valid, 0);
        check("rst_jump", jump_start, 0);
        check("rst_err", seq_err, 0);
        check("rst_seq_en", seq_en, 0);
        rst = 1'b0; step();

        vecs[0] = '{0, 37,       4, 1'b0, 16'd37, 1'b0};
        vecs[1] = '{1, 8'h07,    4, 1'b0, 16'd37, 1'b0};
        vecs[2] = '{0, 0,        3, 1'b0, 16'd0,  1'b0};
        vecs[3] = '{2, 16'h0005, 4, 1'b0, 16'd0,  1'b1};
        vecs[4] = '{2, 16'h030F, 3, 1'b1, 16'd0,  1'b1};
        vecs[5] = '{0, 12,       2, 1'b0, 16'd12, 1'b1};
        for (int v = 0; v < 6; v++) begin
            case (vecs[v].kind)
                0:       run_normal(vecs[v].arg, vecs[v].gp, 0);
                1:       run_jump(8'(vecs[v].arg), vecs[v].gp);
                default: run_bad(8'(vecs[v].arg >> 8), 8'(vecs[v].arg), vecs[v].trig, vecs[v].gp);
            endcase
            check("vec_react", react_time, vecs[v].exp_react);
            check("vec_err", seq_err, vecs[v].exp_err);
        end

        // Reset in the middle of HOLD; start held during reset must be ignored.
        gap = 4;
        start = 1'b1; step(); start = 1'b0;
        wait_lights(8'hFF);
        step(); step(); step();
        rst = 1'b1; start = 1'b1; step();
        check("mid_rst_seq_rst", seq_rst, 0);
        check("mid_rst_lights_off", lights_off, 0);
        check("mid_rst_react", react_time, 0);
        check("mid_rst_valid", time_valid, 0);
        check("mid_rst_jump", jump_start, 0);
        check("mid_rst_err", seq_err, 0);
        step();
        rst = 1'b0; start = 1'b0; step();
        wait_en();
        check("mid_rst_no_arm", seq_en, 0);
        exp_react_m = '0; exp_err_m = 1'b0;

        for (int r = 0; r < 8; r++) begin
            int         kind, gp, k;
            logic [7:0] lvl, val;
            kind = $urandom_range(0, 2);
            gp   = $urandom_range(2, 5);
            k    = $urandom_range(0, 6);
            lvl  = 8'((1 << k) - 1);
            case (kind)
                0: run_normal($urandom_range(0, 60), gp, 0);
                1: run_jump(8'((1 << $urandom_range(0, 7)) - 1), gp);
                default: begin
                    val = 8'($urandom);
                    while (val == lvl || val == {lvl[6:0], 1'b1}) val = 8'($urandom);
                    run_bad(lvl, val, 1'($urandom_range(0, 1)), gp);
                end
            endcase
            check("rand_react", react_time, exp_react_m);
            check("rand_err", seq_err, exp_err_m);
        end

        // Trigger held through DONE, then a second complete run.
        run_normal(9, 4, 5);
        run_normal(3, 4, 0);

        // Saturation on the narrow-counter instance.
        begin
            int t, nt;
            gap = 3;
            start2 = 1'b1; step(); start2 = 1'b0;
            t = 0;
            while (lights_off2 !== 1'b1 && t < 3000) begin step(); t++; end
            check("sat_go", lights_off2, 1);
            nt = 0; t = 0;
            while (nt < 20 && t < 3000) begin step(); t++; if (last_en) nt++; end
            trig2 = 1'b1; step();
            check("sat_valid", time_valid2, 1);
            check("sat_react", react_time2, 15);
            check("sat_err", seq_err2, 0);
            trig2 = 1'b0; step();
            check("sat_jump", jump_start2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
